// File: rtl/timer_intr_pkg.sv
// Shared constants for the timer interrupt controller.
// Holds the register map and the control/status bit positions.
package timer_intr_pkg;

  localparam logic [7:0] ADDR_IER = 8'h00;
  localparam logic [7:0] ADDR_IPR = 8'h01;
  localparam logic [7:0] ADDR_IVR = 8'h02;
  localparam logic [7:0] ADDR_ICR = 8'h03;

  localparam int ICR_GIE   = 0;
  localparam int IVR_VALID = 7;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder for the interrupt controller.
// Bit 0 has the highest priority; id is 0 when nothing is requested.
module intr_prio_enc #(
  parameter int N_SRC = 8
) (
  input  logic [N_SRC-1:0] req,
  output logic [2:0]       id,
  output logic             valid
);

  always_comb begin
    id    = '0;
    valid = |req;
    // Scan downward so the lowest set bit is the last assignment.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = 3'(i);
    end
  end

endmodule

// File: rtl/timer_intr_ctrl.sv
// Interrupt controller behind the timer: edge-detects request lines into a
// pending register, masks them and drives a registered irq plus vector id.
module timer_intr_ctrl
  import timer_intr_pkg::*;
#(
  parameter int N_SRC  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [N_SRC-1:0]  irq_src,
  input  logic              irq_ack,
  output logic              irq,
  output logic [2:0]        irq_id
);

  logic [N_SRC-1:0] ier_q, ier_d;
  logic [N_SRC-1:0] ipr_q, ipr_d;
  logic [N_SRC-1:0] src_q, src_d;
  logic             gie_q, gie_d;
  logic             irq_q, irq_d;

  logic             access;
  logic             wr_en;
  logic             sel_ier, sel_ipr, sel_ivr, sel_icr;
  logic             addr_ok;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] ack_mask;
  logic [N_SRC-1:0] active;
  logic             act_valid;
  logic [DATA_W-1:0] rd_data;

  assign active = ipr_q & ier_q;

  intr_prio_enc #(.N_SRC(N_SRC)) u_prio (
    .req   (active),
    .id    (irq_id),
    .valid (act_valid)
  );

  always_comb begin
    access  = psel & penable;
    wr_en   = access & pwrite;
    sel_ier = (paddr == ADDR_W'(ADDR_IER));
    sel_ipr = (paddr == ADDR_W'(ADDR_IPR));
    sel_ivr = (paddr == ADDR_W'(ADDR_IVR));
    sel_icr = (paddr == ADDR_W'(ADDR_ICR));
    addr_ok = sel_ier | sel_ipr | sel_ivr | sel_icr;

    rd_data = '0;
    if (sel_ier) rd_data[N_SRC-1:0] = ier_q;
    if (sel_ipr) rd_data[N_SRC-1:0] = ipr_q;
    if (sel_ivr) begin
      rd_data[IVR_VALID] = irq_q;
      rd_data[2:0]       = irq_id;
    end
    if (sel_icr) rd_data[ICR_GIE] = gie_q;

    prdata  = access ? rd_data : '0;
    pslverr = access & ~addr_ok;
    pready  = 1'b1;
  end

  always_comb begin
    src_d = irq_src;
    rise  = irq_src & ~src_q;

    ier_d = ier_q;
    if (wr_en && sel_ier) ier_d = pwdata[N_SRC-1:0];

    gie_d = gie_q;
    if (wr_en && sel_icr) gie_d = pwdata[ICR_GIE];

    ack_mask = '0;
    if (irq_ack && irq_q) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (i == int'(irq_id)) ack_mask[i] = 1'b1;
      end
    end

    // Clears first, then new edges OR in so a simultaneous event is kept.
    ipr_d = ipr_q & ~ack_mask;
    if (wr_en && sel_ipr) ipr_d = ipr_d & pwdata[N_SRC-1:0];
    ipr_d = ipr_d | rise;

    irq_d = gie_q & act_valid;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      ier_q <= '0;
      ipr_q <= '0;
      src_q <= '0;
      gie_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      ipr_q <= ipr_d;
      src_q <= src_d;
      gie_q <= gie_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_intr_ctrl.sv
// Directed bench for timer_intr_ctrl: bus access, edge detect, priority,
// acknowledge, masking and reset behaviour with hand-computed expectations.
module tb_timer_intr_ctrl;

  logic       pclk = 1'b0;
  logic       preset;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;
  logic [7:0] irq_src;
  logic       irq_ack;
  logic       irq;
  logic [2:0] irq_id;

  int errors = 0;
  int checks = 0;
  logic [7:0] d;
  logic       e;

  always #5 pclk = ~pclk;

  timer_intr_ctrl dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr),
    .irq_src (irq_src),
    .irq_ack (irq_ack),
    .irq     (irq),
    .irq_id  (irq_id)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge pclk);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = a; pwdata = v;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v, output logic err);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
    #1;
    v = prdata; err = pslverr;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_src = '0; irq_ack = 1'b0;
    step(); step();
    preset = 1'b0;

    // Reset state and register reads
    chk("rst_irq", 8'(irq), 8'h00);
    chk("rst_id", 8'(irq_id), 8'h00);
    chk("pready", 8'(pready), 8'h01);
    chk("idle_prdata", prdata, 8'h00);
    for (int a = 0; a < 4; a++) begin
      rd(8'(a), d, e);
      chk($sformatf("rst_rd%0d", a), d, 8'h00);
      chk($sformatf("rst_err%0d", a), 8'(e), 8'h00);
    end
    rd(8'h04, d, e);
    chk("unmapped_data", d, 8'h00);
    chk("unmapped_err", 8'(e), 8'h01);

    // Enable and fire source 0
    wr(8'h00, 8'h01);
    wr(8'h03, 8'h01);
    irq_src = 8'h01;
    step();
    chk("fire_irq_early", 8'(irq), 8'h00);
    rd(8'h01, d, e);
    chk("fire_ipr", d, 8'h01);
    chk("fire_irq", 8'(irq), 8'h01);
    irq_src = 8'h00;
    rd(8'h02, d, e);
    chk("fire_ivr", d, 8'h80);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step();
    chk("fire_ack_irq", 8'(irq), 8'h00);
    rd(8'h01, d, e);
    chk("fire_ack_ipr", d, 8'h00);

    // Two sources, priority and acknowledge
    wr(8'h00, 8'h03);
    irq_src = 8'h02; step();
    irq_src = 8'h03; step();
    chk("two_id0", 8'(irq_id), 8'h00);
    chk("two_irq", 8'(irq), 8'h01);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    chk("ack1_id", 8'(irq_id), 8'h01);
    rd(8'h01, d, e);
    chk("ack1_ipr", d, 8'h02);
    chk("ack1_irq", 8'(irq), 8'h01);
    rd(8'h02, d, e);
    chk("ack1_ivr", d, 8'h81);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    step();
    chk("ack2_irq", 8'(irq), 8'h00);
    rd(8'h01, d, e);
    chk("ack2_ipr", d, 8'h00);

    // W0C with a held level, then a fresh edge
    wr(8'h01, 8'h00);
    rd(8'h01, d, e);
    chk("held_ipr", d, 8'h00);
    irq_src = 8'h02; step();
    irq_src = 8'h03; step();
    rd(8'h01, d, e);
    chk("reedge_ipr", d, 8'h01);
    irq_src = 8'h00;
    wr(8'h01, 8'h00);
    rd(8'h01, d, e);
    chk("w0c_ipr", d, 8'h00);

    // Set beats a simultaneous W0C clear; writing 1 has no effect
    irq_src = 8'h04;
    wr(8'h01, 8'h00);
    rd(8'h01, d, e);
    chk("collide_ipr", d, 8'h04);
    wr(8'h01, 8'hFF);
    rd(8'h01, d, e);
    chk("w1_noeffect", d, 8'h04);
    irq_src = 8'h00;
    wr(8'h01, 8'h00);

    // IVR writes are ignored without error
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h02; pwdata = 8'hFF;
    #1;
    chk("ivr_wr_err", 8'(pslverr), 8'h00);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    rd(8'h02, d, e);
    chk("ivr_wr_ign", d, 8'h00);

    // Masking via IER
    irq_src = 8'h01; step();
    irq_src = 8'h00; step();
    chk("mask_pre_irq", 8'(irq), 8'h01);
    wr(8'h00, 8'h00);
    step();
    chk("ier_off_irq", 8'(irq), 8'h00);
    rd(8'h01, d, e);
    chk("ier_off_ipr", d, 8'h01);
    wr(8'h00, 8'h01);
    chk("ier_on_early", 8'(irq), 8'h00);
    step();
    chk("ier_on_irq", 8'(irq), 8'h01);

    // Masking via GIE, ack ignored while irq is low
    wr(8'h03, 8'h00);
    step();
    chk("gie_off_irq", 8'(irq), 8'h00);
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
    rd(8'h01, d, e);
    chk("ack_ignored_ipr", d, 8'h01);
    rd(8'h03, d, e);
    chk("icr_off", d, 8'h00);
    wr(8'h03, 8'h01);
    step();
    chk("gie_on_irq", 8'(irq), 8'h01);

    // Reset mid-pending
    preset = 1'b1; step(); preset = 1'b0;
    chk("mid_rst_irq", 8'(irq), 8'h00);
    rd(8'h01, d, e);
    chk("mid_rst_ipr", d, 8'h00);
    rd(8'h00, d, e);
    chk("mid_rst_ier", d, 8'h00);
    rd(8'h03, d, e);
    chk("mid_rst_icr", d, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
